// File: rtl/inpkt_data_gather.sv
// inpkt_data_gather
//   Packs the data bytes qualified by the packet header parser into
//   WORD_WIDTH-bit words. Each word carries the packet type/id of its first
//   byte, an end-of-packet marker and a valid-byte count. Words go into a
//   2-entry FIFO whose head is shown on dout* with no added latency.
//   A parser error drops any partial word and stops gathering until reset.
// Ports
//   CLK, rst_n            clock (posedge), asynchronous active-low reset
//   din, wr_en            byte stream shared with the parser
//   pkt_data, pkt_end     parser qualifiers: data byte / last data byte
//   pkt_err               parser sticky error
//   pkt_type, pkt_id      parser packet type / id
//   full                  upstream must hold wr_en low while high
//   dout, dout_type,
//   dout_id, dout_last,
//   dout_nbytes,
//   dout_valid            head-of-buffer word
//   rd_en                 pop the head word (ignored when empty)
//   err_overflow          sticky: byte strobed while full
//   err                   sticky: parser error seen
module inpkt_data_gather #(
  parameter int WORD_WIDTH   = 16,
  parameter int PKT_TYPE_MSB = 3
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic [7:0]                    din,
  input  logic                          wr_en,
  input  logic                          pkt_data,
  input  logic                          pkt_end,
  input  logic                          pkt_err,
  input  logic [PKT_TYPE_MSB:0]         pkt_type,
  input  logic [15:0]                   pkt_id,
  output logic                          full,
  output logic [WORD_WIDTH-1:0]         dout,
  output logic [PKT_TYPE_MSB:0]         dout_type,
  output logic [15:0]                   dout_id,
  output logic                          dout_last,
  output logic [$clog2(WORD_WIDTH/8):0] dout_nbytes,
  output logic                          dout_valid,
  input  logic                          rd_en,
  output logic                          err_overflow,
  output logic                          err
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BC_W  = $clog2(BYTES);
  localparam int NB_W  = $clog2(BYTES) + 1;

  typedef enum logic {GATHER, ERROR} state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0]   data;
    logic [PKT_TYPE_MSB:0]   ptype;
    logic [15:0]             id;
    logic                    last;
    logic [NB_W-1:0]         nbytes;
  } entry_t;

  state_t                state, state_next;
  logic [BC_W-1:0]       bcnt;
  logic [WORD_WIDTH-1:0] gdata;
  logic [PKT_TYPE_MSB:0] gtype;
  logic [15:0]           gid;
  entry_t                buf0, buf1;
  logic [1:0]            cnt, cnt_next;

  logic                  acc, push, pop, go_err;
  entry_t                new_ent;

  always_comb begin
    go_err  = (state == GATHER) && pkt_err;
    // The error wins over a byte arriving in the same cycle.
    acc     = wr_en && pkt_data && !full && (state == GATHER) && !pkt_err;
    push    = acc && ((bcnt == BC_W'(BYTES - 1)) || pkt_end);
    pop     = rd_en && (cnt != '0);

    // Lanes above bcnt are still zero in gdata, so the pushed word has
    // unwritten lanes at 0 without extra masking.
    new_ent.data   = gdata | (WORD_WIDTH'(din) << {bcnt, 3'b000});
    new_ent.ptype  = (bcnt == '0) ? pkt_type : gtype;
    new_ent.id     = (bcnt == '0) ? pkt_id : gid;
    new_ent.last   = pkt_end;
    new_ent.nbytes = NB_W'(bcnt) + NB_W'(1);

    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + 2'd1;
    else if (pop && !push) cnt_next = cnt - 2'd1;

    state_next = state;
    if (go_err) state_next = ERROR;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= GATHER;
    else        state <= state_next;
  end

  // Gather register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      gdata <= '0;
      gtype <= '0;
      gid   <= '0;
    end else if (go_err) begin
      bcnt  <= '0;
      gdata <= '0;
    end else if (acc) begin
      if (push) begin
        bcnt  <= '0;
        gdata <= '0;
      end else begin
        bcnt  <= bcnt + BC_W'(1);
        gdata <= new_ent.data;
      end
      if (bcnt == '0) begin
        gtype <= pkt_type;
        gid   <= pkt_id;
      end
    end
  end

  // 2-entry shift FIFO; buf0 is always the head.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      full <= (cnt_next == 2'd2);
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) buf0 <= new_ent;
          else           buf1 <= new_ent;
        end
        2'b01: buf0 <= buf1;
        2'b11: begin
          if (cnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= new_ent;
          end else begin
            buf0 <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err          <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (pkt_err)       err          <= 1'b1;
      if (wr_en && full) err_overflow <= 1'b1;
    end
  end

  always_comb begin
    dout        = buf0.data;
    dout_type   = buf0.ptype;
    dout_id     = buf0.id;
    dout_last   = buf0.last;
    dout_nbytes = buf0.nbytes;
    dout_valid  = (cnt != '0);
  end

endmodule

// File: tb/tb_inpkt_data_gather.sv
// Directed self-checking bench for inpkt_data_gather (16-bit words).
module tb_inpkt_data_gather;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        wr_en = 1'b0;
  logic        pkt_data = 1'b0;
  logic        pkt_end = 1'b0;
  logic        pkt_err = 1'b0;
  logic [3:0]  pkt_type = '0;
  logic [15:0] pkt_id = '0;
  logic        full;
  logic [15:0] dout;
  logic [3:0]  dout_type;
  logic [15:0] dout_id;
  logic        dout_last;
  logic [1:0]  dout_nbytes;
  logic        dout_valid;
  logic        rd_en = 1'b0;
  logic        err_overflow;
  logic        err;

  int errors = 0;
  int checks = 0;

  inpkt_data_gather #(.WORD_WIDTH(16), .PKT_TYPE_MSB(3)) dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .pkt_data(pkt_data),
    .pkt_end(pkt_end), .pkt_err(pkt_err), .pkt_type(pkt_type), .pkt_id(pkt_id),
    .full(full), .dout(dout), .dout_type(dout_type), .dout_id(dout_id),
    .dout_last(dout_last), .dout_nbytes(dout_nbytes), .dout_valid(dout_valid),
    .rd_en(rd_en), .err_overflow(err_overflow), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    din = b; wr_en = 1'b1; pkt_data = 1'b1; pkt_end = e;
    tick();
    wr_en = 1'b0; pkt_data = 1'b0; pkt_end = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pkt_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    pkt_data = 1'b0; pkt_end = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  logic [15:0] exp4 [6];
  int sent, popped;
  logic saw_full_low;

  initial begin
    exp4 = '{16'h1110, 16'h1312, 16'h1514, 16'h1716, 16'h1918, 16'h1B1A};

    // Reset state
    #2;
    chk("rst_valid", dout_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", err_overflow, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: 4-byte packet, header byte ignored, type/id latched on first byte
    pkt_type = 4'd2; pkt_id = 16'h1234;
    din = 8'h55; wr_en = 1'b1; pkt_data = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("t1_hdr_ignored", dout_valid, 0);
    send(8'h11, 1'b0);
    pkt_id = 16'hFFFF;
    send(8'h22, 1'b0);
    pkt_id = 16'h1234;
    chk("t1_w0_valid", dout_valid, 1);
    chk("t1_w0_data", dout, 16'h2211);
    chk("t1_w0_nb", dout_nbytes, 2);
    chk("t1_w0_last", dout_last, 0);
    chk("t1_w0_type", dout_type, 2);
    chk("t1_w0_id", dout_id, 16'h1234);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    chk("t1_full", full, 1);
    pop1();
    chk("t1_w1_data", dout, 16'h4433);
    chk("t1_w1_last", dout_last, 1);
    chk("t1_w1_nb", dout_nbytes, 2);
    chk("t1_w1_id", dout_id, 16'h1234);
    chk("t1_unfull", full, 0);
    pop1();
    chk("t1_empty", dout_valid, 0);

    // Test 2: odd-length packet
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t2_w0_data", dout, 16'hBBAA);
    chk("t2_w0_last", dout_last, 0);
    pop1();
    chk("t2_w1_data", dout, 16'h00CC);
    chk("t2_w1_nb", dout_nbytes, 1);
    chk("t2_w1_last", dout_last, 1);
    pop1();
    chk("t2_empty", dout_valid, 0);

    // Test 3: overflow while full
    do_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("t3_full", full, 1);
    chk("t3_ovf_pre", err_overflow, 0);
    send(8'hEE, 1'b0);
    chk("t3_ovf", err_overflow, 1);
    chk("t3_still_full", full, 1);
    chk("t3_w0", dout, 16'h0201);
    pop1();
    chk("t3_w1", dout, 16'h0403);
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    pop1();
    chk("t3_w2", dout, 16'h0605);
    chk("t3_w2_last", dout_last, 1);
    pop1();
    chk("t3_empty", dout_valid, 0);

    // Test 4: full buffer drained with rd_en every cycle, continuous bytes
    do_reset();
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    chk("t4_full", full, 1);
    sent = 0; popped = 0; saw_full_low = 1'b0;
    for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
      rd_en = 1'b1;
      if (!full && sent < 8) begin
        din = 8'(8'h14 + sent);
        wr_en = 1'b1; pkt_data = 1'b1; pkt_end = (sent == 7);
        sent++;
      end else begin
        wr_en = 1'b0; pkt_data = 1'b0; pkt_end = 1'b0;
      end
      if (!full) saw_full_low = 1'b1;
      if (dout_valid) begin
        chk($sformatf("t4_word%0d", popped), dout, exp4[popped]);
        if (popped == 5) chk("t4_last", dout_last, 1);
        popped++;
      end
      tick();
    end
    rd_en = 1'b0; wr_en = 1'b0; pkt_data = 1'b0; pkt_end = 1'b0;
    chk("t4_popped", popped, 6);
    chk("t4_full_dropped", saw_full_low, 1);
    tick();
    chk("t4_empty", dout_valid, 0);
    chk("t4_no_ovf", err_overflow, 0);

    // Test 5: parser error with one word buffered and a partial word
    do_reset();
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    pkt_err = 1'b1;
    tick();
    chk("t5_err", err, 1);
    send(8'h24, 1'b1);
    tick();
    chk("t5_valid", dout_valid, 1);
    chk("t5_word", dout, 16'h2221);
    chk("t5_last", dout_last, 0);
    pop1();
    tick();
    tick();
    chk("t5_no_partial", dout_valid, 0);
    chk("t5_err_sticky", err, 1);

    // Test 6: asynchronous reset mid-packet
    do_reset();
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    chk("t6_pre_valid", dout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", dout_valid, 0);
    chk("t6_async_dout", dout, 0);
    chk("t6_async_full", full, 0);
    #2;
    rst_n = 1'b1;
    tick();
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    chk("t6_word", dout, 16'h4241);
    chk("t6_nb", dout_nbytes, 2);
    chk("t6_last", dout_last, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
